// File: rtl/ncl_counter_sync_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ncl_pkg
// Shared definitions for the clocked endpoint of the dual-rail NCL counter
// ring: rail code constants, the carry transmitter state type and small
// decode helpers for a 2-bit dual-rail channel.
// ---------------------------------------------------------------------------
package ncl_pkg;

  // Dual-rail codes, bit [1] = DATA1 rail, bit [0] = DATA0 rail
  localparam logic [1:0] RAIL_NULL    = 2'b00;
  localparam logic [1:0] RAIL_DATA0   = 2'b01;
  localparam logic [1:0] RAIL_DATA1   = 2'b10;
  localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_NULL = 2'd2
  } tx_state_t;

  function automatic logic is_data(input logic [1:0] rail);
    return (rail == RAIL_DATA0) || (rail == RAIL_DATA1);
  endfunction

  function automatic logic is_null(input logic [1:0] rail);
    return (rail == RAIL_NULL);
  endfunction

  function automatic logic is_illegal(input logic [1:0] rail);
    return (rail == RAIL_ILLEGAL);
  endfunction

endpackage

// File: rtl/ncl_counter_sync_bridge_if.sv
// ---------------------------------------------------------------------------
// ncl_counter_sync_bridge_if
// Clocked-side handshakes of the NCL counter bridge:
//   inc_valid/inc_data/inc_ready          token request port
//   count_valid/count_ready/count_data/
//   count_ovf                             assembled count word port
// slave  = the bridge, master = the agent issuing tokens / taking words.
// ---------------------------------------------------------------------------
interface ncl_counter_sync_bridge_if #(
  parameter int NDIGITS = 32
) ();

  logic               inc_valid;
  logic               inc_data;
  logic               inc_ready;
  logic               count_valid;
  logic               count_ready;
  logic [NDIGITS-1:0] count_data;
  logic               count_ovf;

  modport master (
    output inc_valid, inc_data, count_ready,
    input  inc_ready, count_valid, count_data, count_ovf
  );

  modport slave (
    input  inc_valid, inc_data, count_ready,
    output inc_ready, count_valid, count_data, count_ovf
  );

endinterface

// File: rtl/ncl_counter_sync_bridge_rail_sync.sv
// ---------------------------------------------------------------------------
// ncl_rail_sync
// Synchronizes one asynchronous dual-rail channel into the clk domain with a
// SYNC_STAGES flip-flop chain and decodes the synchronized code.
// Ports:
//   clk, init       clock, synchronous active-high clear
//   rail_in[1:0]    async rails ([1]=DATA1, [0]=DATA0); with SINGLE_RAIL only
//                   rail_in[0] is used and is treated as a completion level
//   data_s          synchronized DATA0 or DATA1
//   null_s          synchronized NULL
//   illegal_s       synchronized 11
//   one_s           synchronized DATA1
// ---------------------------------------------------------------------------
module ncl_rail_sync
  import ncl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit SINGLE_RAIL = 1'b0
) (
  input  logic       clk,
  input  logic       init,
  input  logic [1:0] rail_in,
  output logic       data_s,
  output logic       null_s,
  output logic       illegal_s,
  output logic       one_s
);

  logic [1:0] rail_in_s;
  logic [1:0] chain_r [SYNC_STAGES];
  logic [1:0] tail_s;

  // A single completion level is mapped onto the rail code space as
  // high -> DATA1, low -> NULL, so one decoder serves both variants.
  assign rail_in_s = SINGLE_RAIL ? {rail_in[0], 1'b0} : rail_in;
  assign tail_s    = chain_r[SYNC_STAGES-1];

  // Synchronizer chain, every stage cleared by init
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_r[i] <= RAIL_NULL;
      end
    end else begin
      chain_r[0] <= rail_in_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign data_s    = is_data(tail_s);
  assign null_s    = is_null(tail_s);
  assign illegal_s = is_illegal(tail_s);
  assign one_s     = (tail_s == RAIL_DATA1);

endmodule

// File: rtl/ncl_counter_sync_bridge.sv
// ---------------------------------------------------------------------------
// ncl_counter_sync_bridge
// Clocked endpoint of the dual-rail NCL counter ring.
// Ports:
//   clk, init       sole clock, synchronous active-high reset (also resets ring)
//   bus (slave)     inc_valid/inc_data/inc_ready token port,
//                   count_valid/count_ready/count_data/count_ovf word port
//   carryin_o[1:0]  dual-rail carry wavefront into the LSB digit
//   bcomp_i         LSB digit completion (high = digit holds DATA)
//   sum_i           dual-rail digit sums, digit k on [2k+1:2k]
//   sumcomp_o       per-digit sum completion back to the ring
//   carryout_i      dual-rail MSB carryout
//   carrycomp_o     carryout completion back to the ring
//   rail_err        sticky flag: a synchronized 11 code was observed
// Channel index NDIGITS in the internal vectors is the carryout channel.
// ---------------------------------------------------------------------------
module ncl_counter_sync_bridge
  import ncl_pkg::*;
#(
  parameter int NDIGITS     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   init,
  ncl_counter_sync_bridge_if.slave bus,
  output logic [1:0]             carryin_o,
  input  logic                   bcomp_i,
  input  logic [2*NDIGITS-1:0]   sum_i,
  output logic [NDIGITS-1:0]     sumcomp_o,
  input  logic [1:0]             carryout_i,
  output logic                   carrycomp_o,
  output logic                   rail_err
);

  localparam int NCH = NDIGITS + 1;

  tx_state_t  state_r;
  logic [1:0] carryin_r;
  logic       inc_ready_s;

  logic       bcomp_data_s;
  logic       bcomp_null_s;
  logic       bcomp_ill_s;
  logic       bcomp_one_s;

  logic [NCH-1:0] ch_data_s;
  logic [NCH-1:0] ch_null_s;
  logic [NCH-1:0] ch_ill_s;
  logic [NCH-1:0] ch_one_s;

  logic [NCH-1:0] full_r;
  logic [NCH-1:0] comp_r;
  logic [NCH-1:0] cap_r;
  logic           rail_err_r;
  logic           count_valid_s;
  logic           accept_s;

  // ---------------- synchronizers ----------------
  ncl_rail_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .SINGLE_RAIL (1'b1)
  ) u_bcomp_sync (
    .clk       (clk),
    .init      (init),
    .rail_in   ({1'b0, bcomp_i}),
    .data_s    (bcomp_data_s),
    .null_s    (bcomp_null_s),
    .illegal_s (bcomp_ill_s),
    .one_s     (bcomp_one_s)
  );

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [1:0] rail;
      if (k < NDIGITS) begin : g_sum
        assign rail = sum_i[2*k +: 2];
      end else begin : g_carry
        assign rail = carryout_i;
      end
      ncl_rail_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .SINGLE_RAIL (1'b0)
      ) u_sync (
        .clk       (clk),
        .init      (init),
        .rail_in   (rail),
        .data_s    (ch_data_s[k]),
        .null_s    (ch_null_s[k]),
        .illegal_s (ch_ill_s[k]),
        .one_s     (ch_one_s[k])
      );
    end
  endgenerate

  // ---------------- carry transmitter ----------------
  assign inc_ready_s = (state_r == TX_IDLE) & ~bcomp_one_s & ~init;

  // Carry wavefront sequencer: one token in flight, DATA held until the LSB
  // digit completes, then NULL until it releases; the DATA code is the
  // registered copy of inc_data.
  always_ff @(posedge clk) begin
    if (init) begin
      state_r   <= TX_IDLE;
      carryin_r <= RAIL_NULL;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (bus.inc_valid && inc_ready_s) begin
            state_r   <= TX_DATA;
            carryin_r <= bus.inc_data ? RAIL_DATA1 : RAIL_DATA0;
          end
        end
        TX_DATA: begin
          if (bcomp_data_s) begin
            state_r   <= TX_NULL;
            carryin_r <= RAIL_NULL;
          end
        end
        TX_NULL: begin
          if (bcomp_null_s) begin
            state_r <= TX_IDLE;
          end
        end
        default: begin
          state_r   <= TX_IDLE;
          carryin_r <= RAIL_NULL;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  assign count_valid_s = &full_r;
  assign accept_s      = count_valid_s & bus.count_ready;

  // Per-channel capture and completion handshake. A capture needs full==0,
  // so it can never coincide with a word accept (which needs every flag
  // set); the accept clear is therefore applied last without conflict.
  // Illegal codes decode as neither DATA nor NULL and are simply ignored.
  always_ff @(posedge clk) begin
    if (init) begin
      full_r <= {NCH{1'b0}};
      comp_r <= {NCH{1'b0}};
      cap_r  <= {NCH{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_data_s[k] && !comp_r[k] && !full_r[k]) begin
          cap_r[k]  <= ch_one_s[k];
          full_r[k] <= 1'b1;
          comp_r[k] <= 1'b1;
        end else if (ch_null_s[k] && comp_r[k]) begin
          comp_r[k] <= 1'b0;
        end
      end
      if (accept_s) begin
        full_r <= {NCH{1'b0}};
      end
    end
  end

  // Sticky illegal-code flag, cleared only by init
  always_ff @(posedge clk) begin
    if (init) begin
      rail_err_r <= 1'b0;
    end else if ((|ch_ill_s) || bcomp_ill_s) begin
      rail_err_r <= 1'b1;
    end
  end

  assign carryin_o       = carryin_r;
  assign sumcomp_o       = comp_r[NDIGITS-1:0];
  assign carrycomp_o     = comp_r[NDIGITS];
  assign rail_err        = rail_err_r;
  assign bus.inc_ready   = inc_ready_s;
  assign bus.count_valid = count_valid_s;
  assign bus.count_data  = cap_r[NDIGITS-1:0];
  assign bus.count_ovf   = cap_r[NDIGITS];

endmodule
